// File: rtl/rb_fifo_pkg.sv
// Shared types and helpers for the rb_fifo_v2 ring-buffer FIFO.
// Optional sticky error flags are enabled by RB_FIFO_ERR_EN (see rb_fifo_v2.sv).
package rb_fifo_pkg;

  typedef struct packed {
    logic full;
    logic empty;
    logic almost_full;
    logic almost_empty;
  } status_t;

  // Explicit compare keeps the wrap correct for non-power-of-two depths.
  function automatic int wrap_inc(int ptr, int depth);
    return (ptr == depth - 1) ? 0 : ptr + 1;
  endfunction

  function automatic int cnt_next(int cnt, logic push_ok, logic pop_ok);
    return cnt + (push_ok ? 1 : 0) - (pop_ok ? 1 : 0);
  endfunction

  function automatic status_t status_of(int cnt, int depth, int af_lvl, int ae_lvl);
    status_t s;
    s.full         = (cnt == depth);
    s.empty        = (cnt == 0);
    s.almost_full  = (cnt >= af_lvl);
    s.almost_empty = (cnt <= ae_lvl);
    return s;
  endfunction

endpackage

// File: rtl/rb_fifo_v2_if.sv
// Producer/consumer bus of rb_fifo_v2; overflow/underflow exist only with RB_FIFO_ERR_EN.
interface rb_fifo_v2_if #(
  parameter int DW = 2,
  parameter int CW = 3
);
  logic          clr;
  logic          push;
  logic          pop;
  logic [DW-1:0] data_in;
  logic [DW-1:0] data_out;
  logic          full;
  logic          empty;
  logic          almost_full;
  logic          almost_empty;
  logic [CW-1:0] count;
`ifdef RB_FIFO_ERR_EN
  logic          overflow;
  logic          underflow;

  modport master (
    output clr, push, pop, data_in,
    input  data_out, full, empty, almost_full, almost_empty, count, overflow, underflow
  );
  modport slave (
    input  clr, push, pop, data_in,
    output data_out, full, empty, almost_full, almost_empty, count, overflow, underflow
  );
`else
  modport master (
    output clr, push, pop, data_in,
    input  data_out, full, empty, almost_full, almost_empty, count
  );
  modport slave (
    input  clr, push, pop, data_in,
    output data_out, full, empty, almost_full, almost_empty, count
  );
`endif
endinterface

// File: rtl/rb_fifo_ptr.sv
// Modulo-DEPTH pointer register with synchronous clear and increment.
module rb_fifo_ptr
  import rb_fifo_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic          clock,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          inc,
  output logic [AW-1:0] ptr
);

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n)   ptr <= '0;
    else if (clr) ptr <= '0;
    else if (inc) ptr <= AW'(wrap_inc(int'(ptr), DEPTH));
  end

endmodule

// File: rtl/rb_fifo_v2.sv
// Ring-buffer FIFO, any DEPTH >= 2, first-word fall-through, registered status.
// Define RB_FIFO_ERR_EN to add sticky overflow/underflow flags.
module rb_fifo_v2
  import rb_fifo_pkg::*;
#(
  parameter int DW     = 2,
  parameter int DEPTH  = 4,
  parameter int AF_LVL = 3,
  parameter int AE_LVL = 1
) (
  input logic         clock,
  input logic         rst_n,
  rb_fifo_v2_if.slave bus
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam status_t ST_RST = status_of(0, DEPTH, AF_LVL, AE_LVL);

  logic [AW-1:0] head, tail;
  logic [CW-1:0] count_q, count_n;
  status_t       st_q, st_n;
  logic          push_ok, pop_ok;
  logic [DW-1:0] mem [DEPTH];

  // A pop on a full FIFO frees the slot the same-cycle push fills.
  assign push_ok = bus.push & (~st_q.full | bus.pop);
  assign pop_ok  = bus.pop & ~st_q.empty;

  always_comb begin
    count_n = bus.clr ? '0 : CW'(cnt_next(int'(count_q), push_ok, pop_ok));
    st_n    = status_of(int'(count_n), DEPTH, AF_LVL, AE_LVL);
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
      st_q    <= ST_RST;
    end else begin
      count_q <= count_n;
      st_q    <= st_n;
    end
  end

  always_ff @(posedge clock) begin
    if (push_ok && !bus.clr) mem[tail] <= bus.data_in;
  end

  rb_fifo_ptr #(.DEPTH(DEPTH), .AW(AW)) u_head (
    .clock (clock),
    .rst_n (rst_n),
    .clr   (bus.clr),
    .inc   (pop_ok),
    .ptr   (head)
  );

  rb_fifo_ptr #(.DEPTH(DEPTH), .AW(AW)) u_tail (
    .clock (clock),
    .rst_n (rst_n),
    .clr   (bus.clr),
    .inc   (push_ok),
    .ptr   (tail)
  );

  assign bus.data_out     = st_q.empty ? '0 : mem[head];
  assign bus.full         = st_q.full;
  assign bus.empty        = st_q.empty;
  assign bus.almost_full  = st_q.almost_full;
  assign bus.almost_empty = st_q.almost_empty;
  assign bus.count        = count_q;

`ifdef RB_FIFO_ERR_EN
  logic ovf_q, unf_q;

  // Sticky until reset or flush; a push+pop pair is never an error.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else if (bus.clr) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      if (bus.push && st_q.full && !bus.pop)  ovf_q <= 1'b1;
      if (bus.pop && st_q.empty && !bus.push) unf_q <= 1'b1;
    end
  end

  assign bus.overflow  = ovf_q;
  assign bus.underflow = unf_q;
`endif

endmodule

// File: tb/tb_rb_fifo_v2.sv
// Directed bench for rb_fifo_v2: DEPTH=4 and DEPTH=3 instances checked against a queue model.
module tb_rb_fifo_v2;

  logic clock = 1'b0;
  logic rst_n = 1'b1;
  always #5 clock = ~clock;

  rb_fifo_v2_if #(.DW(2), .CW(3)) a_if ();
  rb_fifo_v2_if #(.DW(2), .CW(2)) b_if ();

  rb_fifo_v2 #(.DW(2), .DEPTH(4), .AF_LVL(3), .AE_LVL(1)) u_a (
    .clock (clock), .rst_n (rst_n), .bus (a_if.slave)
  );
  rb_fifo_v2 #(.DW(2), .DEPTH(3), .AF_LVL(2), .AE_LVL(1)) u_b (
    .clock (clock), .rst_n (rst_n), .bus (b_if.slave)
  );

  int checks = 0;
  int errors = 0;
  logic [1:0] qa[$];
  logic [1:0] qb[$];
`ifdef RB_FIFO_ERR_EN
  logic ovf_a = 1'b0, unf_a = 1'b0;
`endif

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_a(string tag);
    chk({tag, ".count"}, 32'(a_if.count), qa.size());
    chk({tag, ".empty"}, 32'(a_if.empty), 32'(qa.size() == 0));
    chk({tag, ".full"},  32'(a_if.full),  32'(qa.size() == 4));
    chk({tag, ".afull"}, 32'(a_if.almost_full),  32'(qa.size() >= 3));
    chk({tag, ".aempty"},32'(a_if.almost_empty), 32'(qa.size() <= 1));
    chk({tag, ".dout"},  32'(a_if.data_out), (qa.size() != 0) ? 32'(qa[0]) : 32'd0);
`ifdef RB_FIFO_ERR_EN
    chk({tag, ".ovf"},   32'(a_if.overflow),  32'(ovf_a));
    chk({tag, ".unf"},   32'(a_if.underflow), 32'(unf_a));
`endif
  endtask

  task automatic check_b(string tag);
    chk({tag, ".count"}, 32'(b_if.count), qb.size());
    chk({tag, ".empty"}, 32'(b_if.empty), 32'(qb.size() == 0));
    chk({tag, ".full"},  32'(b_if.full),  32'(qb.size() == 3));
    chk({tag, ".afull"}, 32'(b_if.almost_full), 32'(qb.size() >= 2));
    chk({tag, ".dout"},  32'(b_if.data_out), (qb.size() != 0) ? 32'(qb[0]) : 32'd0);
  endtask

  // Drive one cycle on instance A, then update the model and compare.
  task automatic step_a(string tag, bit ps, bit pp, logic [1:0] d, bit cl = 1'b0);
    logic [1:0] dout_pre;
    logic [1:0] exp;
    bit push_ok, pop_ok;
    a_if.push = ps; a_if.pop = pp; a_if.data_in = d; a_if.clr = cl;
    #1;
    dout_pre = a_if.data_out;
    @(posedge clock);
    if (cl) begin
      qa.delete();
`ifdef RB_FIFO_ERR_EN
      ovf_a = 1'b0; unf_a = 1'b0;
`endif
    end else begin
      push_ok = ps && (qa.size() < 4 || pp);
      pop_ok  = pp && (qa.size() > 0);
`ifdef RB_FIFO_ERR_EN
      if (ps && qa.size() == 4 && !pp) ovf_a = 1'b1;
      if (pp && qa.size() == 0 && !ps) unf_a = 1'b1;
`endif
      if (pop_ok) begin
        exp = qa.pop_front();
        chk({tag, ".pop"}, 32'(dout_pre), 32'(exp));
      end
      if (push_ok) qa.push_back(d);
    end
    #1;
    a_if.push = 1'b0; a_if.pop = 1'b0; a_if.clr = 1'b0;
    check_a(tag);
  endtask

  task automatic step_b(string tag, bit ps, bit pp, logic [1:0] d);
    logic [1:0] dout_pre;
    logic [1:0] exp;
    bit push_ok, pop_ok;
    b_if.push = ps; b_if.pop = pp; b_if.data_in = d;
    #1;
    dout_pre = b_if.data_out;
    @(posedge clock);
    push_ok = ps && (qb.size() < 3 || pp);
    pop_ok  = pp && (qb.size() > 0);
    if (pop_ok) begin
      exp = qb.pop_front();
      chk({tag, ".pop"}, 32'(dout_pre), 32'(exp));
    end
    if (push_ok) qb.push_back(d);
    #1;
    b_if.push = 1'b0; b_if.pop = 1'b0;
    check_b(tag);
  endtask

  initial begin
    a_if.push = 0; a_if.pop = 0; a_if.clr = 0; a_if.data_in = '0;
    b_if.push = 0; b_if.pop = 0; b_if.clr = 0; b_if.data_in = '0;
    #1 rst_n = 1'b0;
    #2;
    check_a("reset");
    check_b("reset_b");
    @(posedge clock); #1 rst_n = 1'b1;

    // Fill, then drain in order.
    for (int i = 0; i < 4; i++) step_a("fill", 1, 0, 2'(i));
    for (int i = 0; i < 4; i++) step_a("drain", 0, 1, 2'b0);

    // Push+pop on full keeps count; the new word emerges after the old three.
    for (int i = 0; i < 4; i++) step_a("fill2", 1, 0, 2'(i));
    step_a("full_pp", 1, 1, 2'd2);
    for (int i = 0; i < 4; i++) step_a("drain2", 0, 1, 2'b0);

    // Push+pop on empty: push only.
    step_a("empty_pp", 1, 1, 2'd3);
    step_a("empty_pp_pop", 0, 1, 2'b0);

    // Rejected push on full and pop on empty.
    for (int i = 0; i < 4; i++) step_a("fill3", 1, 0, 2'(3 - i));
    step_a("ovf", 1, 0, 2'd1);
    step_a("ovf_hold", 0, 0, 2'd0);
    for (int i = 0; i < 4; i++) step_a("drain3", 0, 1, 2'b0);
    step_a("unf", 0, 1, 2'b0);
    step_a("err_clr", 0, 0, 2'b0, 1'b1);

    // Flush beats a same-cycle push.
    for (int i = 0; i < 3; i++) step_a("fill4", 1, 0, 2'(i + 1));
    step_a("clr_push", 1, 0, 2'd2, 1'b1);
    step_a("after_clr", 1, 0, 2'd1);

    // Asynchronous reset mid-burst, checked before any clock edge.
    step_a("burst", 1, 0, 2'd3);
    a_if.push = 1'b1; a_if.data_in = 2'd2;
    #2 rst_n = 1'b0;
    #1;
    qa.delete();
    qb.delete();
`ifdef RB_FIFO_ERR_EN
    ovf_a = 1'b0; unf_a = 1'b0;
`endif
    check_a("async_rst");
    @(posedge clock); #1;
    a_if.push = 1'b0;
    rst_n = 1'b1;

    // Random mix against the model.
    for (int i = 0; i < 40; i++)
      step_a("rand", 1'($urandom_range(1)), 1'($urandom_range(1)), 2'($urandom_range(3)));
    for (int i = 0; i < 5; i++) step_a("rand_drain", 0, 1, 2'b0);

    // DEPTH=3: pointer wrap through alternating push/pop.
    for (int i = 0; i < 10; i++) begin
      step_b("alt_push", 1, 0, 2'(i));
      step_b("alt_pop", 0, 1, 2'b0);
    end
    for (int i = 0; i < 3; i++) step_b("b_fill", 1, 0, 2'(i + 1));
    step_b("b_full_pp", 1, 1, 2'd0);
    for (int i = 0; i < 3; i++) step_b("b_drain", 0, 1, 2'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: observed no finish, expected finish before 50000");
    $fatal(1, "timeout");
  end

endmodule
